rr_grant_arbiter: RTL

//  - Round-robin arbiter sharing one resource among 8 requesters.
//  - Holds a registered grant until the winner finishes (done) or drops its request.
//  - Grant index drives a 3-to-8 enable decoder, which produces the one-hot grant bus.
//  - Sits in front of a shared datapath; the one-hot gnt bus is its select/enable.

---
 rtl/rr_grant_arbiter_pkg.sv | 21 ++
 rtl/rr_grant_arbiter_dec.sv | 22 ++
 rtl/rr_grant_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg (package)
//  Description : Shared sizing constants and state type for the round-robin
//                grant arbiter. The requester count is fixed at 8, so the
//                grant index is 3 bits wide.
//  Contents    : N, IDXW, arb_state_t
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_grant_arbiter_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec3to8
//  Description : Combinational 3-to-8 one-hot decoder with enable. With en
//                low the output is all zero.
//  Ports       : en     in   1  decoder enable
//                x      in   3  binary index
//                z      out  8  one-hot output (bit x set when en)
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec3to8 (
    input  logic       en,
    input  logic [2:0] x,
    output logic [7:0] z
);

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign z[i] = en && (x == 3'(i));
    end

endmodule : onehot_dec3to8
`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_arbiter
//  Description : Round-robin arbiter sharing one resource among 8 requesters.
//                A winner keeps its grant until it signals done or drops its
//                request. The search for the next winner starts one past the
//                previous holder, wrapping 7 -> 0. There is always at least
//                one idle cycle between two consecutive grants.
//  Config      : RR_GRANT_TIMEOUT_EN - when defined, a grant is forcibly
//                released after MAX_HOLD grant cycles and the timeout port
//                pulses for one cycle.
//  Ports       : clk        in   1  clock, rising edge
//                rst        in   1  synchronous active-high reset
//                en         in   1  arbitration enable (blocks new grants)
//                req        in   8  request vector
//                done       in   1  holder finished this cycle
//                gnt        out  8  one-hot grant
//                gnt_idx    out  3  index of the holder
//                gnt_valid  out  1  a grant is active
//                timeout    out  1  forced-release pulse (macro only)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter
    import arb_pkg::*;
`ifdef RR_GRANT_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
`ifdef RR_GRANT_TIMEOUT_EN
    output logic            timeout,
`endif
    output logic            gnt_valid
);

    // ------------------------------------------------------------------
    // Rotating priority search: the first set request at or after ptr,
    // modulo N. Returns {found, index}. Walking the offsets from highest
    // to lowest lets the smallest offset overwrite the result last.
    // ------------------------------------------------------------------
    function automatic logic [IDXW:0] f_rr_pick(
        input logic [N-1:0]    f_req,
        input logic [IDXW-1:0] f_ptr
    );
        logic [IDXW:0]   v_res;
        logic [IDXW-1:0] v_idx;
        v_res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            v_idx = f_ptr + IDXW'(k);
            if (f_req[v_idx]) begin
                v_res = {1'b1, v_idx};
            end
        end
        return v_res;
    endfunction

    arb_state_t      r_state;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] r_idx;
    logic            r_valid;

    logic [IDXW:0]   w_pick;
    logic            w_pick_found;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_req_lost;
    logic            w_release;

    assign w_pick       = f_rr_pick(req, r_ptr);
    assign w_pick_found = w_pick[IDXW];
    assign w_pick_idx   = w_pick[IDXW-1:0];
    assign w_req_lost   = !req[r_idx];

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int c_hold_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [c_hold_w-1:0] r_hold;
    logic                r_timeout;
    logic                w_hold_hit;

    assign w_hold_hit = (r_hold == c_hold_w'(MAX_HOLD - 1));
    assign w_release  = done || w_req_lost || w_hold_hit;
    assign timeout    = r_timeout;
`else
    assign w_release  = done || w_req_lost;
`endif

    // ------------------------------------------------------------------
    // Two-state grant FSM. Everything downstream sees only registered
    // values; release and new grant can never share an edge, which
    // produces the mandatory idle bubble between holders.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef RR_GRANT_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (r_state == IDLE) begin
                if (en && w_pick_found) begin
                    r_state <= GRANT;
                    r_idx   <= w_pick_idx;
                    r_valid <= 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
                    r_hold  <= '0;
`endif
                end
            end else begin
                if (w_release) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ptr   <= r_idx + IDXW'(1);
`ifdef RR_GRANT_TIMEOUT_EN
                    // A normal release on the same cycle wins over the
                    // hold limit, so no timeout is reported then.
                    r_timeout <= w_hold_hit && !done && !w_req_lost;
`endif
                end
`ifdef RR_GRANT_TIMEOUT_EN
                else begin
                    r_hold <= r_hold + c_hold_w'(1);
                end
`endif
            end
        end
    end

    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

    onehot_dec3to8 u_dec (
        .en (r_valid),
        .x  (r_idx),
        .z  (gnt)
    );

endmodule : rr_grant_arbiter
`default_nettype wire
